// File: rtl/tetris_input_conditioner_pkg.sv
// Shared definitions for the tetris button conditioner: button indices,
// channel count and the per-channel auto-repeat state encoding.
package tetris_pkg;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_ROTATE = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_DROP   = 4;

  localparam int NBTN = 5;

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_DELAY,
    REP_RATE
  } rep_state_t;

endpackage

// File: rtl/tetris_input_conditioner_btn_channel.sv
// One button channel: 2-flop synchronizer, debounce filter, press pulse and,
// when TETRIS_AUTO_REPEAT_EN is defined and REPEAT_EN is set, hold-to-repeat.
module btn_channel
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 2,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 10,
  parameter bit REPEAT_EN    = 1'b0
) (
  input  logic hz100,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_pulse_d
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]    sync_q;
  logic          s;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          press;
  logic          rep_pulse;

  assign s = sync_q[1];

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      dcnt_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // The level only flips after s has disagreed with it for DEBOUNCE_CYC samples.
  always_comb begin
    level_d = level_q;
    dcnt_d  = dcnt_q;
    if (s == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DW'(DEBOUNCE_CYC - 1)) begin
      level_d = s;
      dcnt_d  = '0;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  assign press = level_d & ~level_q;

`ifdef TETRIS_AUTO_REPEAT_EN
  if (REPEAT_EN) begin : g_rep
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    rep_state_t    state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rep_d;

    always_ff @(posedge hz100 or posedge reset) begin
      if (reset) begin
        state_q <= REP_IDLE;
        rcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
      end
    end

    // A release seen on the same edge as a due repeat suppresses that repeat.
    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      rep_d   = 1'b0;
      if (!level_d) begin
        state_d = REP_IDLE;
        rcnt_d  = '0;
      end else begin
        case (state_q)
          REP_IDLE: begin
            if (press) begin
              state_d = REP_DELAY;
              rcnt_d  = '0;
            end
          end
          REP_DELAY: begin
            if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
              rep_d   = 1'b1;
              rcnt_d  = '0;
              state_d = REP_RATE;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          REP_RATE: begin
            if (rcnt_q == RW'(REPEAT_RATE - 1)) begin
              rep_d  = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
          default: begin
            state_d = REP_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end
    end

    assign rep_pulse = rep_d;
  end else begin : g_norep
    assign rep_pulse = 1'b0;
  end
`else
  // Repeat settings are accepted for interface compatibility but have no effect here.
  if (REPEAT_EN && (REPEAT_DELAY > 0) && (REPEAT_RATE > 0)) begin : g_rep_off
    assign rep_pulse = 1'b0;
  end else begin : g_norep
    assign rep_pulse = 1'b0;
  end
`endif

  assign pulse_d     = press | rep_pulse;
  assign btn_level   = level_q;
  assign btn_pulse   = pulse_q;
  assign btn_pulse_d = pulse_d;

endmodule

// File: rtl/tetris_input_conditioner.sv
// Push-button conditioner for the tetris game: NBTN independent channels plus a
// registered any_pulse. Define TETRIS_AUTO_REPEAT_EN to build hold-to-repeat.
module tetris_input_conditioner #(
  parameter int              NBTN         = tetris_pkg::NBTN,
  parameter int              DEBOUNCE_CYC = 2,
  parameter int              REPEAT_DELAY = 30,
  parameter int              REPEAT_RATE  = 10,
  parameter logic [NBTN-1:0] REPEAT_MASK  = 5'b00011
) (
  input  logic            hz100,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_pulse,
  output logic            any_pulse
);

  logic [NBTN-1:0] pulse_d;
  logic            any_q;

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .REPEAT_EN   (REPEAT_MASK[i])
    ) u_ch (
      .hz100      (hz100),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_pulse  (btn_pulse[i]),
      .btn_pulse_d(pulse_d[i])
    );
  end

  // Registered from the channels' next-pulse terms so it lines up with btn_pulse.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |pulse_d;
    end
  end

  assign any_pulse = any_q;

endmodule

// File: tb/tb_tetris_input_conditioner.sv
// Self-checking bench for tetris_input_conditioner: directed scenarios plus
// random button activity compared every cycle against a behavioural model.
module tb_tetris_input_conditioner;

  localparam int NB = 5;
  localparam int DB = 2;
  localparam int RD = 30;
  localparam int RR = 10;

  logic          hz100 = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic          any_pulse;

  tetris_input_conditioner dut (
    .hz100    (hz100),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .any_pulse(any_pulse)
  );

  always #5 hz100 = ~hz100;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at t=%0t actual=%b required=%b", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [NB-1:0] rep_mask = 5'b00011;
`ifdef TETRIS_AUTO_REPEAT_EN
  bit rep_on = 1'b1;
`else
  bit rep_on = 1'b0;
`endif

  logic [NB-1:0] m_s1, m_s2, m_lvl, m_pulse;
  logic          m_any;
  int            m_diff [NB];
  int            m_press[NB];
  int            cyc;
  logic          was;
  int            k;

  always @(posedge hz100 or posedge reset) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0; m_any = 1'b0; cyc = 0;
      for (int i = 0; i < NB; i++) begin m_diff[i] = 0; m_press[i] = 0; end
    end else begin
      cyc++;
      for (int i = 0; i < NB; i++) begin
        was = m_lvl[i];
        // Level follows s once s has disagreed for DB consecutive samples.
        if (m_s2[i] != m_lvl[i]) begin
          m_diff[i]++;
          if (m_diff[i] == DB) begin m_lvl[i] = m_s2[i]; m_diff[i] = 0; end
        end else begin
          m_diff[i] = 0;
        end
        m_pulse[i] = 1'b0;
        if (m_lvl[i] && !was) begin
          m_pulse[i] = 1'b1;
          m_press[i] = cyc;
        end else if (rep_on && rep_mask[i] && m_lvl[i]) begin
          k = cyc - m_press[i];
          m_pulse[i] = (k >= RD) && (((k - RD) % RR) == 0);
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
      m_any = |m_pulse;
    end
  end

  // ---------------- compare and pulse logging ----------------
  int   pulse_cnt[NB];
  int   p1_q[$];
  logic chk_en = 1'b0;

  initial for (int i = 0; i < NB; i++) pulse_cnt[i] = 0;

  always @(negedge hz100) begin
    if (!reset && chk_en) begin
      check("model_level", btn_level, m_lvl);
      check("model_pulse", btn_pulse, m_pulse);
      check("model_any", {4'b0, any_pulse}, {4'b0, m_any});
    end
    if (!reset) begin
      for (int i = 0; i < NB; i++) if (btn_pulse[i]) pulse_cnt[i]++;
      if (btn_pulse[1]) p1_q.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge hz100);
  endtask

  logic [31:0] exp_q[$];
  int          c0;

  initial begin
    // Outputs are held at zero during reset.
    #12;
    check("reset_level", btn_level, '0);
    check("reset_pulse", btn_pulse, '0);
    check("reset_any", {4'b0, any_pulse}, '0);
    @(negedge hz100);
    reset = 1'b0;
    chk_en = 1'b1;
    step(2);

    // Press latency on rotate: level and pulse rise after edge 4.
    btn_raw[2] = 1'b1;
    step(3);
    check("press_e3_level", {4'b0, btn_level[2]}, 5'd0);
    step(1);
    check("press_e4_level", {4'b0, btn_level[2]}, 5'd1);
    check("press_e4_pulse", {4'b0, btn_pulse[2]}, 5'd1);
    step(1);
    check("press_e5_pulse", {4'b0, btn_pulse[2]}, 5'd0);
    btn_raw[2] = 1'b0;
    step(10);

    // One-cycle glitch is rejected.
    c0 = pulse_cnt[2];
    btn_raw[2] = 1'b1;
    step(1);
    btn_raw[2] = 1'b0;
    step(10);
    check("glitch_level", {4'b0, btn_level[2]}, 5'd0);
    check("glitch_pulses", 5'(pulse_cnt[2] - c0), 5'd0);

    // Three-cycle press is accepted with a single pulse.
    c0 = pulse_cnt[2];
    btn_raw[2] = 1'b1;
    step(3);
    btn_raw[2] = 1'b0;
    step(10);
    check("short_press_pulses", 5'(pulse_cnt[2] - c0), 5'd1);

    // Non-repeat start channel held 100 cycles.
    c0 = pulse_cnt[3];
    btn_raw[3] = 1'b1;
    step(100);
    check("hold_start_pulses", 5'(pulse_cnt[3] - c0), 5'd1);
    btn_raw[3] = 1'b0;
    step(3);
    check("release_e3_level", {4'b0, btn_level[3]}, 5'd1);
    step(1);
    check("release_e4_level", {4'b0, btn_level[3]}, 5'd0);
    step(5);
    check("release_no_pulse", 5'(pulse_cnt[3] - c0), 5'd1);

    // Left held 80 cycles: repeats when built in; release lands on a due repeat.
    p1_q.delete();
    exp_q.delete();
    exp_q.push_back(0);
    if (rep_on) for (int t = RD; t < 80; t += RR) exp_q.push_back(t);
    btn_raw[1] = 1'b1;
    step(80);
    btn_raw[1] = 1'b0;
    step(10);
    check("repeat_count", 5'(p1_q.size()), 5'(exp_q.size()));
    while (exp_q.size() > 0 && p1_q.size() > 0) begin
      check("repeat_spacing", 5'(p1_q[p1_q.size() - exp_q.size()] - p1_q[0]), 5'(exp_q[0]));
      void'(exp_q.pop_front());
      if (exp_q.size() > p1_q.size()) break;
    end

    // Simultaneous presses on right and rotate.
    btn_raw[0] = 1'b1;
    btn_raw[2] = 1'b1;
    step(4);
    check("simul_pulse", btn_pulse & 5'b00101, 5'b00101);
    check("simul_any", {4'b0, any_pulse}, 5'd1);
    step(1);
    check("simul_any_next", {4'b0, any_pulse}, 5'd0);
    btn_raw = '0;
    step(10);

    // Reset mid-operation with right and left held.
    btn_raw = 5'b00011;
    step(10);
    #2 reset = 1'b1;
    #1;
    check("midreset_level", btn_level, '0);
    check("midreset_pulse", btn_pulse, '0);
    check("midreset_any", {4'b0, any_pulse}, '0);
    @(negedge hz100);
    reset = 1'b0;
    step(3);
    check("rst_rel_e3_level", btn_level, 5'b00000);
    step(1);
    check("rst_rel_e4_level", btn_level, 5'b00011);
    check("rst_rel_e4_pulse", btn_pulse, 5'b00011);
    step(1);
    check("rst_rel_e5_pulse", btn_pulse, 5'b00000);
    btn_raw = '0;
    step(10);

    // Random button activity, including glitches and long holds.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) btn_raw[$urandom_range(0, NB - 1)] ^= 1'b1;
      step(1);
    end
    btn_raw = '0;
    step(10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
